sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO for buffering data between tt_um_* datapath stages.

---
 rtl/sync_fifo_param.sv | 158 +++++++++++++++
 tb/tb_sync_fifo_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow errors and a selectable first-word-fall-through mode.
// Optional feature macro: FIFO_PEAK_EN adds a 'peak' output tracking the maximum occupancy
// since reset or clr_err.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 1,
  parameter bit          FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
`ifdef FIFO_PEAK_EN
  ,
  output logic [ADDR_W:0]   peak
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_fire;
  logic              rd_fire;

  assign wr_fire = wr_en & ~full_q;
  assign rd_fire = rd_en & ~empty_q;

  // Next-state for pointers, occupancy, flags and sticky errors
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + CW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + CW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clr_err must survive the clear
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en && full_q)  ovf_d = 1'b1;
    if (rd_en && empty_q) unf_d = 1'b1;
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
    af_d    = (count_d >= CW'(AF_THRESH));
    ae_d    = (count_d <= CW'(AE_THRESH));
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents survive reset, reset only blocks new writes
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly from the array
      assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end else begin : g_reg
      logic [DATA_W-1:0] rd_data_q, rd_data_d;

      // Capture the head word on each accepted pop, hold otherwise
      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_fire) rd_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end

      // Registered read data
      always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

`ifdef FIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark, restarted from the current occupancy on clr_err
  always_comb begin
    peak_d = peak_q;
    if (clr_err)               peak_d = count_d;
    else if (count_d > peak_q) peak_d = count_d;
  end

  // Peak register
  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: one registered-read and one FWFT instance share stimulus.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] rd0, rd1;
  logic [3:0] cnt0, cnt1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
`ifdef FIFO_PEAK_EN
  logic [3:0] peak0, peak1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
`ifdef FIFO_PEAK_EN
    , .peak(peak0)
`endif
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
`ifdef FIFO_PEAK_EN
    , .peak(peak1)
`endif
  );

  typedef struct {
    logic       rst, wr_en, rd_en, clr;
    logic [7:0] wd;
    logic [3:0] cnt;
    logic       full, empty, af, ae, ovf, unf;
    logic       chk_rd;
    logic [7:0] rd;
    logic       chk_fw;
    logic [7:0] fw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic w, input logic rd_e, input logic c,
                              input logic [7:0] wd, input logic [3:0] cnt, input logic f,
                              input logic e, input logic af, input logic ae, input logic ov,
                              input logic un, input logic chk_rd, input logic [7:0] rdv,
                              input logic chk_fw, input logic [7:0] fwv);
    vec_t v;
    v.rst = r; v.wr_en = w; v.rd_en = rd_e; v.clr = c; v.wd = wd; v.cnt = cnt;
    v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
    v.chk_rd = chk_rd; v.rd = rdv; v.chk_fw = chk_fw; v.fw = fwv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic rd_e, input logic c,
                       input logic [7:0] wd);
    rst = r; wr_en = w; rd_en = rd_e; clr_err = c; wr_data = wd;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] cnt, input logic f, input logic e,
                           input logic af, input logic ae, input logic ov, input logic un);
    chk({tag, ".count"}, 32'(cnt0), 32'(cnt));
    chk({tag, ".full"}, 32'(full0), 32'(f));
    chk({tag, ".empty"}, 32'(empty0), 32'(e));
    chk({tag, ".almost_full"}, 32'(af0), 32'(af));
    chk({tag, ".almost_empty"}, 32'(ae0), 32'(ae));
    chk({tag, ".overflow"}, 32'(ovf0), 32'(ov));
    chk({tag, ".underflow"}, 32'(unf0), 32'(un));
    chk({tag, ".fwft_flags"}, 32'({cnt1, full1, empty1, af1, ae1, ovf1, unf1}),
        32'({cnt, f, e, af, ae, ov, un}));
  endtask

  initial begin
    // Tests 1-3: fill, overflow, drain, underflow
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 4'd0, 0, 1, 0, 1, 0, 0, 1, 8'h00, 0, 8'h00));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, 0, 0, 8'(8'h10 + k), 4'(k), k == 8, 0, k >= 6, k <= 1, 0, 0,
                        1, 8'h00, 1, 8'h11));
    vecs.push_back(mk(0, 1, 0, 0, 8'h99, 4'd8, 1, 0, 1, 0, 1, 0, 1, 8'h00, 1, 8'h11));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 4'd8, 1, 0, 1, 0, 0, 0, 1, 8'h00, 1, 8'h11));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 4'(8 - k), 0, k == 8, (8 - k) >= 6, (8 - k) <= 1,
                        0, 0, 1, 8'(8'h10 + k), k < 8, 8'(8'h11 + k)));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 4'd0, 0, 1, 0, 1, 0, 1, 1, 8'h18, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 4'd0, 0, 1, 0, 1, 0, 1, 1, 8'h18, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 4'd0, 0, 1, 0, 1, 0, 0, 1, 8'h18, 0, 8'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr_en, vecs[i].rd_en, vecs[i].clr, vecs[i].wd);
      step();
      chk_flags($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].af,
                vecs[i].ae, vecs[i].ovf, vecs[i].unf);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d.rd_data", i), 32'(rd0), 32'(vecs[i].rd));
      if (vecs[i].chk_fw) chk($sformatf("vec%0d.fwft_rd", i), 32'(rd1), 32'(vecs[i].fw));
    end

    // Test 4: steady-state wrap-around at count=4
    drive(1, 0, 0, 0, 8'h00); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 8'(8'h40 + i)); step();
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("wrap.pre_count", 32'(cnt0), 32'd4);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 0, 8'(8'h44 + i)); step();
      chk($sformatf("wrap%0d.count", i), 32'(cnt0), 32'd4);
      chk($sformatf("wrap%0d.rd_data", i), 32'(rd0), 32'(8'h40 + i));
      chk($sformatf("wrap%0d.fwft_rd", i), 32'(rd1), 32'(8'h41 + i));
    end
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 1, 0, 8'h00); step();
      chk($sformatf("wrap_drain%0d.rd_data", j), 32'(rd0), 32'(8'h54 + j));
      chk($sformatf("wrap_drain%0d.count", j), 32'(cnt0), 32'(3 - j));
    end

    // Full with simultaneous read and write: write refused, read accepted
    drive(1, 0, 0, 0, 8'h00); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 8'(8'h60 + i)); step();
    end
    drive(0, 1, 1, 0, 8'h77); step();
    chk_flags("full_rw", 4'd7, 0, 0, 1, 0, 1, 0);
    chk("full_rw.rd_data", 32'(rd0), 32'h60);
    for (int j = 1; j < 8; j++) begin
      drive(0, 0, 1, 0, 8'h00); step();
      chk($sformatf("full_rw_drain%0d.rd_data", j), 32'(rd0), 32'(8'h60 + j));
    end
    chk("full_rw.drained_empty", 32'(empty0), 32'd1);

    // Test 5: FWFT write into empty FIFO
    drive(1, 0, 0, 1, 8'h00); step();
    drive(0, 1, 0, 0, 8'hA5); step();
    drive(0, 0, 0, 0, 8'h00);
    chk("fwft.rd_data", 32'(rd1), 32'hA5);
    chk("fwft.empty", 32'(empty1), 32'd0);
    step();
    chk("fwft.hold_rd_data", 32'(rd1), 32'hA5);
    drive(0, 0, 1, 0, 8'h00); step();
    drive(0, 0, 0, 0, 8'h00);
    chk("fwft.pop_empty", 32'(empty1), 32'd1);
    chk("fwft.reg_rd_data", 32'(rd0), 32'hA5);

    // Test 6: reset dominates a write with count=5
    drive(1, 0, 0, 0, 8'h00); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 8'(8'hC0 + i)); step();
    end
    chk("rst.pre_count", 32'(cnt0), 32'd5);
`ifdef FIFO_PEAK_EN
    chk("rst.pre_peak", 32'(peak0), 32'd5);
`endif
    drive(1, 1, 0, 0, 8'hEE); step();
    drive(0, 0, 0, 0, 8'h00);
    chk_flags("rst", 4'd0, 0, 1, 0, 1, 0, 0);
    chk("rst.rd_data", 32'(rd0), 32'h00);
`ifdef FIFO_PEAK_EN
    chk("rst.peak", 32'(peak0), 32'd0);
    chk("rst.peak_fwft", 32'(peak1), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
